// File: rtl/vga_pkg.sv
// Shared VGA constants and the rectangle-controller state encoding.
// Macro DRAW_RECT_CTL_BOUNCE_EN adds the BOUNCE state to the encoding.
package vga_pkg;

  localparam int SCREEN_W_DEF = 1024;
  localparam int SCREEN_H_DEF = 768;
  localparam int RECT_W_DEF   = 64;
  localparam int RECT_H_DEF   = 64;
  localparam int VEL_MAX      = 63;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FALL   = 2'd1,
`ifdef DRAW_RECT_CTL_BOUNCE_EN
    BOUNCE = 2'd2,
`endif
    DONE   = 2'd3
  } rect_state_t;

  // Clamp a 12-bit coordinate to an upper limit.
  function automatic logic [11:0] clamp_max(input logic [11:0] v, input logic [11:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/draw_rect_ctl_frame_tick.sv
// frame_tick: vsync rising-edge detector producing a one-cycle frame pulse.
// The pulse is registered, so it appears one cycle after the edge is seen.
// After reset the detector waits to observe vsync low before it arms, so a
// vsync already high at reset release does not count as a new edge.
module frame_tick (
  input  logic pclk,
  input  logic rst,
  input  logic vsync_in,
  output logic tick
);

  logic vsync_reg;
  logic armed_reg;
  logic tick_reg;

  // Track previous vsync, arm on first low sample, register the edge pulse.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      vsync_reg <= 1'b0;
      armed_reg <= 1'b0;
      tick_reg  <= 1'b0;
    end else begin
      vsync_reg <= vsync_in;
      armed_reg <= armed_reg | ~vsync_in;
      tick_reg  <= vsync_in & ~vsync_reg & armed_reg;
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/draw_rect_ctl.sv
// draw_rect_ctl: rectangle follows the mouse in IDLE; a left click drops it
// under gravity, one step per frame tick, until it lands at the bottom.
// Macro DRAW_RECT_CTL_BOUNCE_EN enables damped bouncing after impact;
// without it the rectangle stops at the first impact.
module draw_rect_ctl
  import vga_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int RECT_W   = RECT_W_DEF,
  parameter int RECT_H   = RECT_H_DEF,
  parameter int GRAVITY  = 1
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        mouse_left,
  output logic [11:0] xpos,
  output logic [11:0] ypos
);

  localparam logic [11:0] X_MAX   = 12'(SCREEN_W - RECT_W);
  localparam logic [11:0] Y_MAX   = 12'(SCREEN_H - RECT_H);
  localparam logic [6:0]  GRAV    = 7'(GRAVITY);
  localparam logic [6:0]  VEL_SAT = 7'(VEL_MAX);

  rect_state_t state_reg, state_next;
  logic [11:0] xpos_reg, xpos_next;
  logic [11:0] ypos_reg, ypos_next;
  logic [6:0]  vel_reg, vel_next;

  logic        tick;
  logic [12:0] y_sum;
  logic [7:0]  vel_inc;
  logic [6:0]  vel_fall;
`ifdef DRAW_RECT_CTL_BOUNCE_EN
  logic [6:0]  vel_damp;
  logic [11:0] y_rise;
  logic [6:0]  vel_dec;
`endif

  frame_tick u_frame_tick (
    .pclk     (pclk),
    .rst      (rst),
    .vsync_in (vsync_in),
    .tick     (tick)
  );

  // State and position registers; reset may arrive at any point of a drop.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      xpos_reg  <= '0;
      ypos_reg  <= '0;
      vel_reg   <= '0;
    end else begin
      state_reg <= state_next;
      xpos_reg  <= xpos_next;
      ypos_reg  <= ypos_next;
      vel_reg   <= vel_next;
    end
  end

  // Next-state and motion arithmetic; everything holds unless a case updates it.
  always_comb begin
    state_next = state_reg;
    xpos_next  = xpos_reg;
    ypos_next  = ypos_reg;
    vel_next   = vel_reg;

    y_sum    = {1'b0, ypos_reg} + {6'd0, vel_reg};
    vel_inc  = {1'b0, vel_reg} + {1'b0, GRAV};
    vel_fall = (vel_inc > {1'b0, VEL_SAT}) ? VEL_SAT : vel_inc[6:0];
`ifdef DRAW_RECT_CTL_BOUNCE_EN
    vel_damp = vel_reg - (vel_reg >> 2);
    y_rise   = (ypos_reg > {5'd0, vel_reg}) ? (ypos_reg - {5'd0, vel_reg}) : 12'd0;
    vel_dec  = (vel_reg > GRAV) ? (vel_reg - GRAV) : 7'd0;
`endif

    case (state_reg)
      IDLE: begin
        xpos_next = clamp_max(mouse_xpos, X_MAX);
        ypos_next = clamp_max(mouse_ypos, Y_MAX);
        if (mouse_left) begin
          state_next = FALL;
          vel_next   = '0;
        end
      end
      FALL: begin
        if (tick) begin
          if (y_sum < {1'b0, Y_MAX}) begin
            ypos_next = y_sum[11:0];
            vel_next  = vel_fall;
          end else begin
            ypos_next = Y_MAX;
`ifdef DRAW_RECT_CTL_BOUNCE_EN
            // Impact loses a quarter of the speed; too slow to bounce means rest.
            vel_next   = vel_damp;
            state_next = (vel_damp >= 7'd2) ? BOUNCE : DONE;
`else
            state_next = DONE;
`endif
          end
        end
      end
`ifdef DRAW_RECT_CTL_BOUNCE_EN
      BOUNCE: begin
        if (tick) begin
          ypos_next = y_rise;
          vel_next  = vel_dec;
          if (vel_dec == 7'd0) state_next = FALL;
        end
      end
`endif
      DONE: begin
        if (!mouse_left) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign xpos = xpos_reg;
  assign ypos = ypos_reg;

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Directed self-checking bench for draw_rect_ctl (default 1024x768, 64x64 rect).
// Expectations follow DRAW_RECT_CTL_BOUNCE_EN when it is defined.
`timescale 1ns/1ps
module tb_draw_rect_ctl;
  import vga_pkg::*;

  logic        pclk = 1'b0;
  logic        rst = 1'b0;
  logic        vsync_in = 1'b0;
  logic        mouse_left = 1'b0;
  logic [11:0] mouse_xpos = '0;
  logic [11:0] mouse_ypos = '0;
  logic [11:0] xpos;
  logic [11:0] ypos;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  draw_rect_ctl dut (
    .pclk       (pclk),
    .rst        (rst),
    .vsync_in   (vsync_in),
    .mouse_xpos (mouse_xpos),
    .mouse_ypos (mouse_ypos),
    .mouse_left (mouse_left),
    .xpos       (xpos),
    .ypos       (ypos)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic set_mouse(input int x, input int y);
    mouse_xpos = 12'(x);
    mouse_ypos = 12'(y);
  endtask

  // One vsync pulse; the FSM consumes the tick two edges after vsync rises.
  task automatic frame();
    vsync_in = 1'b1;
    step(3);
    vsync_in = 1'b0;
    step(2);
    $display("frame: xpos=%0d ypos=%0d state=%0d vel=%0d", xpos, ypos, int'(dut.state_reg), dut.vel_reg);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    step(2);
  endtask

  int fall_exp[4]   = '{200, 201, 203, 206};
  int drop_exp[5]   = '{694, 695, 697, 700, 704};
  int bounce_exp[3] = '{701, 699, 698};
  int seen;

  initial begin
    // Reset values while held
    #1;
    check_val("rst_xpos", int'(xpos), 0);
    check_val("rst_ypos", int'(ypos), 0);
    check_val("rst_state", int'(dut.state_reg), int'(IDLE));
    step(2);
    rst = 1'b1;
    step(2);

    // Tracking and clamping
    set_mouse(100, 200);
    step(1);
    $display("track: mouse=(100,200) -> xpos=%0d ypos=%0d", xpos, ypos);
    check_val("track_x", int'(xpos), 100);
    check_val("track_y", int'(ypos), 200);
    set_mouse(1000, 750);
    step(1);
    $display("track: mouse=(1000,750) -> xpos=%0d ypos=%0d", xpos, ypos);
    check_val("clamp_x", int'(xpos), 960);
    check_val("clamp_y", int'(ypos), 704);

    // Fall from 200
    set_mouse(100, 200);
    step(1);
    mouse_left = 1'b1;
    step(1);
    check_val("press_state", int'(dut.state_reg), int'(FALL));
    check_val("press_vel", int'(dut.vel_reg), 0);
    check_val("press_y", int'(ypos), 200);
    mouse_left = 1'b0;
    set_mouse(500, 500);
    step(1);
    check_val("fall_ignore_btn", int'(dut.state_reg), int'(FALL));
    for (int i = 0; i < 4; i++) begin
      frame();
      check_val($sformatf("fall_y%0d", i), int'(ypos), fall_exp[i]);
      check_val($sformatf("fall_x%0d", i), int'(xpos), 100);
    end
    step(4);
    check_val("fall_hold_y", int'(ypos), 206);
    check_val("fall_hold_vel", int'(dut.vel_reg), 4);

    // Asynchronous reset mid-fall, vsync already high
    vsync_in = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    $display("reset mid-fall: xpos=%0d ypos=%0d", xpos, ypos);
    check_val("midrst_x", int'(xpos), 0);
    check_val("midrst_y", int'(ypos), 0);
    check_val("midrst_state", int'(dut.state_reg), int'(IDLE));
    check_val("midrst_vel", int'(dut.vel_reg), 0);
    step(2);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (dut.u_frame_tick.tick_reg) seen = 1;
    end
    check_val("no_tick_after_rst", seen, 0);
    vsync_in = 1'b0;
    step(2);

    // Drop from 694 to impact, button held throughout
    set_mouse(100, 694);
    step(1);
    check_val("drop_start_y", int'(ypos), 694);
    mouse_left = 1'b1;
    step(1);
    for (int i = 0; i < 5; i++) begin
      frame();
      check_val($sformatf("drop_y%0d", i), int'(ypos), drop_exp[i]);
    end
`ifdef DRAW_RECT_CTL_BOUNCE_EN
    check_val("impact_state", int'(dut.state_reg), int'(BOUNCE));
    check_val("impact_vel", int'(dut.vel_reg), 3);
    for (int i = 0; i < 3; i++) begin
      frame();
      check_val($sformatf("bounce_y%0d", i), int'(ypos), bounce_exp[i]);
    end
    check_val("bounce_end_state", int'(dut.state_reg), int'(FALL));
`else
    check_val("impact_state", int'(dut.state_reg), int'(DONE));
    for (int i = 0; i < 2; i++) begin
      frame();
      check_val($sformatf("rest_y%0d", i), int'(ypos), 704);
    end
    check_val("rest_state", int'(dut.state_reg), int'(DONE));
`endif
    mouse_left = 1'b0;
    do_reset();

    // Settle into DONE from 703, then hold and release
    set_mouse(50, 703);
    step(1);
    mouse_left = 1'b1;
    step(1);
    frame();
    check_val("done_t1_y", int'(ypos), 703);
    frame();
    check_val("done_t2_y", int'(ypos), 704);
    check_val("done_state", int'(dut.state_reg), int'(DONE));
    set_mouse(10, 20);
    step(3);
    check_val("done_hold_x", int'(xpos), 50);
    check_val("done_hold_y", int'(ypos), 704);
    check_val("done_hold_state", int'(dut.state_reg), int'(DONE));
    mouse_left = 1'b0;
    step(1);
    check_val("release_state", int'(dut.state_reg), int'(IDLE));
    check_val("release_y_held", int'(ypos), 704);
    step(1);
    $display("release: mouse=(10,20) -> xpos=%0d ypos=%0d", xpos, ypos);
    check_val("release_track_x", int'(xpos), 10);
    check_val("release_track_y", int'(ypos), 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/draw_rect_ctl.md
DRAW_RECT_CTL -- requirements
Module: draw_rect_ctl

Interface
REQ-001 Parameter SCREEN_W, default 1024, visible width in pixels.
REQ-002 Parameter SCREEN_H, default 768, visible height in pixels.
REQ-003 Parameters RECT_W and RECT_H, default 64 each, size of the controlled rectangle.
REQ-004 Parameter GRAVITY, default 1, velocity increment per frame.
REQ-005 Port pclk, input, 1, the single pixel clock; all logic SHALL be clocked on its rising edge.
REQ-006 Port rst, input, 1, asynchronous active-low reset.
REQ-007 Port vsync_in, input, 1, vertical sync from the timing stage, used only as the frame tick source.
REQ-008 Port mouse_xpos, input, 12, mouse X in pixels.
REQ-009 Port mouse_ypos, input, 12, mouse Y in pixels.
REQ-010 Port mouse_left, input, 1, left button, synchronous to pclk.
REQ-011 Port xpos, output, 12, registered rectangle X, consumed by draw_rect.
REQ-012 Port ypos, output, 12, registered rectangle Y, consumed by draw_rect.

Function
REQ-013 Frame tick SHALL be a one-cycle pulse, one cycle after a registered rising edge of vsync_in.
REQ-014 States SHALL be IDLE, FALL, BOUNCE and DONE; the velocity register vel SHALL be 7 bits unsigned and SHALL saturate at 63.
REQ-015 Definitions: X_MAX = SCREEN_W-RECT_W and Y_MAX = SCREEN_H-RECT_H.
REQ-016 IDLE: each cycle, xpos <= min(mouse_xpos, X_MAX) and ypos <= min(mouse_ypos, Y_MAX), with one-cycle latency.
REQ-017 IDLE with mouse_left=1: the FSM SHALL go to FALL and clear vel; the mouse sample is still taken that cycle; xpos SHALL then be frozen until IDLE.
REQ-018 FALL, on tick: if ypos+vel < Y_MAX, then ypos <= ypos+vel and vel <= vel+GRAVITY.
REQ-019 FALL, on tick when ypos+vel >= Y_MAX: ypos <= Y_MAX; vel <= vel-(vel>>2); the next state SHALL be BOUNCE if that result is >= 2, else DONE.
REQ-020 BOUNCE, on tick: ypos <= max(ypos-vel, 0) and vel <= vel-GRAVITY, floored at 0; when the new vel is 0, the next state SHALL be FALL.
REQ-021 DONE: outputs SHALL be held; mouse_left=0 SHALL return the FSM to IDLE on the next cycle.
REQ-022 mouse_left SHALL be ignored in FALL and BOUNCE.
REQ-023 Between ticks, ypos and vel SHALL not change outside IDLE.

Reset
REQ-024 rst=0 SHALL asynchronously force state IDLE and set xpos=0, ypos=0, vel=0, and the vsync edge register to 0, including mid-FALL or mid-BOUNCE.
REQ-025 After rst deasserts, the first tick SHALL be produced only by a new rising edge of vsync_in.

Configuration
REQ-026 Macro DRAW_RECT_CTL_BOUNCE_EN defined: BOUNCE behaviour is per REQ-019/REQ-020.
REQ-027 Macro undefined: the BOUNCE state and damping logic SHALL be absent, and impact (REQ-019) SHALL set ypos <= Y_MAX and go directly to DONE.

Structure
REQ-028 The state enum and the default screen and rectangle constants SHALL live in the shared package vga_pkg.
REQ-029 Frame-tick generation SHALL be one sub-module, frame_tick (vsync edge detect to one-cycle pulse); the FSM and arithmetic stay in draw_rect_ctl.

Verification
REQ-030 Reset: rst=0 during FALL -> the same cycle, xpos=0, ypos=0, state IDLE.
REQ-031 Tracking: mouse (100,200) -> next cycle xpos=100, ypos=200; mouse (1000,750) -> xpos=960, ypos=704.
REQ-032 Fall: ypos=200, press, 4 ticks -> ypos 200, 201, 203, 206; xpos unchanged.
REQ-033 Bounce (macro on): ypos=694, press, 5 ticks -> 694, 695, 697, 700, 704, BOUNCE with vel=3; 3 more ticks -> 701, 699, 698, then FALL.
REQ-034 No bounce (macro off): same stimulus -> tick 5 gives ypos=704 and DONE; further ticks leave ypos=704.
REQ-035 DONE with mouse_left held -> outputs hold; release -> IDLE next cycle, with ypos following mouse one cycle later.
